multicycle_ctrl_unit: RTL
=========================

// Module: multicycle_ctrl_unit
// PURPOSE
//  Parametrised multi-cycle control unit for the 8-bit CPU.
//  Sequences FETCH/DECODE/EXEC/MEM/WB, decodes the opcode into datapath controls, and stalls on cache busywait.
//  Resolves jump/beq into a PC select. Sits between the instruction cache, data cache, register file, ALU and PC register.
// PARAMETERS
//  INSTR_W   32  instruction width; opcode = INSTRUCTION[INSTR_W-1 -: OPCODE_W]
//  OPCODE_W  8   opcode field width (>=4)
//  ALUOP_W   3   ALUOP width (>=3); upper bits zero
// PORTS
//  CLK              in   1         system clock, rising edge
//  RESET            in   1         asynchronous, active-low reset
//  INSTRUCTION      in   INSTR_W   instruction from I-cache
//  INSTR_VALID      in   1         INSTRUCTION valid this cycle
//  MEM_BUSYWAIT     in   1         D-cache stall request
//  ZERO             in   1         ALU zero flag
//  WRITEENABLE      out  1         register-file write strobe
//  ALUOP            out  ALUOP_W   ALU function select
//  COMPLEMENT_FLAG  out  1         negate operand 2 (sub/beq)
//  IMMEDIATE_FLAG   out  1         operand 2 from immediate field
//  MEM_READ         out  1         D-cache read request
//  MEM_WRITE        out  1         D-cache write request
//  MEM_TO_REG       out  1         writeback data from D-cache
//  PC_SEL           out  2         00 PC+4, 01 jump target, 10 branch target
//  PC_UPDATE        out  1         PC register load strobe
//  ILLEGAL_OP       out  1         one-cycle pulse, undefined opcode
//  STATE            out  3         debug: current state code
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4; codes 5-7 -> FETCH next edge.
//  All outputs are functions of registered state only; no comb. path from inputs.
//  Reset (RESET=0): immediate state=FETCH, every output 0, opcode reg 0.
//   Applies mid-operation: MEM_READ/MEM_WRITE drop without waiting for CLK.
//  FETCH: wait for INSTR_VALID=1; on that edge latch opcode -> DECODE.
//  DECODE: controls registered from opcode on DECODE->EXEC edge.
//   ALUOP/COMPLEMENT/IMMEDIATE held until the next FETCH, then cleared.
//  EXEC: 1 cycle. ZERO sampled at exit edge into a branch register.
//   ILLEGAL_OP=1 here for undefined opcodes, then NOP behaviour.
//   lwd/lwi/swd/swi -> MEM; all others -> WB.
//  MEM: MEM_READ (loads) or MEM_WRITE (stores) high for the whole state.
//   Minimum 1 cycle. Leave on first edge with MEM_BUSYWAIT=0 -> WB.
//  WB: 1 cycle. PC_UPDATE=1; WRITEENABLE=1 for reg-writing ops.
//   MEM_TO_REG=1 for loads. PC_SEL: j -> 01; beq -> 10 if sampled ZERO else 00.
//   -> FETCH.
//  Latency: non-memory op 4 cycles from valid fetch edge. Memory op 5+N, N = busywait-high edges in MEM.
//  Opcode decode (ALUOP / COMP / IMM / other). Unlisted opcodes are illegal: WE=0, PC_SEL=00.
//   0 loadi 000/0/1 WE    1 mov 000/0/0 WE     2 add 001/0/0 WE
//   3 sub   001/1/0 WE    4 and 010/0/0 WE     5 or  011/0/0 WE
//   6 j     000/0/0 PC_SEL=01                  7 beq 001/1/0 PC_SEL=10 if ZERO
//   8 lwd 000/0/0 RD WE M2R  9 lwi 000/0/1 RD WE M2R
//   10 swd 000/0/0 WR        11 swi 000/0/1 WR
//  Opcode compared zero-extended; bits above bit 7 nonzero -> illegal.
// CONFIGURATION
//  CTRL_SHIFT_OPS_EN defined: opcodes 12-15 legal, all IMM=1 WE:
//   sll=100, srl=101, sra=110, ror=111.
//  CTRL_SHIFT_OPS_EN undefined: opcodes 12-15 illegal (ILLEGAL_OP pulse, no write).
// TESTING
//  1. RESET=0 2 cycles, release; add 0x02040102 with VALID=1 -> DECODE, EXEC (ALUOP=001), WB (WE=1, PC_UPDATE=1, PC_SEL=00), FETCH; 4 cycles.
//  2. sub 0x03040102 -> ALUOP=001, COMPLEMENT_FLAG=1 from EXEC; loadi 0x00040005 -> IMMEDIATE_FLAG=1.
//  3. beq with ZERO=1 in EXEC -> WB PC_SEL=10, WE=0; repeat ZERO=0 -> PC_SEL=00. j -> PC_SEL=01.
//  4. lwd, MEM_BUSYWAIT=1 for 3 edges then 0 -> MEM 4 cycles with MEM_READ=1; WB: WE=1, MEM_TO_REG=1; total 8 cycles.
//  5. swi with BUSYWAIT=1, drive RESET=0 mid-MEM -> MEM_WRITE=0 and STATE=0 before next CLK edge.
//  6. Opcode 0x0C: macro on -> ALUOP=100, WE in WB; macro off -> ILLEGAL_OP pulse, WE=0.
//     Opcode 0xFF -> ILLEGAL_OP pulse in both builds.

Source files
------------

// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle control unit for the 8-bit CPU.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> WB, decodes the latched opcode
// into datapath controls and resolves j/beq into a PC select.
// Optional feature macro: CTRL_SHIFT_OPS_EN (opcodes 12-15 become shift/rotate ops).
module multicycle_ctrl_unit #(
    parameter int INSTR_W  = 32,
    parameter int OPCODE_W = 8,
    parameter int ALUOP_W  = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    input  logic               INSTR_VALID,
    input  logic               MEM_BUSYWAIT,
    input  logic               ZERO,
    output logic               WRITEENABLE,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic               COMPLEMENT_FLAG,
    output logic               IMMEDIATE_FLAG,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic               MEM_TO_REG,
    output logic [1:0]         PC_SEL,
    output logic               PC_UPDATE,
    output logic               ILLEGAL_OP,
    output logic [2:0]         STATE
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [OPCODE_W-1:0] r_opcode;

    // Registered control bundle, valid from EXEC until the return to FETCH
    logic [2:0] r_aluop;
    logic       r_comp, r_imm, r_we, r_rd, r_wr, r_m2r, r_j, r_beq, r_illegal;
    logic       r_zero;

    // Combinational decode of the latched opcode
    logic [2:0] w_dec_aluop;
    logic       w_dec_comp, w_dec_imm, w_dec_we, w_dec_rd, w_dec_wr;
    logic       w_dec_m2r, w_dec_j, w_dec_beq, w_dec_illegal;

    // Only the opcode field of the instruction word matters to control
    logic w_unused_operand;
    assign w_unused_operand = ^INSTRUCTION[INSTR_W-OPCODE_W-1:0];

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; unused codes fall back to FETCH
    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_state_next = INSTR_VALID ? S_DECODE : S_FETCH;
            S_DECODE: w_state_next = S_EXEC;
            S_EXEC:   w_state_next = (r_rd || r_wr) ? S_MEM : S_WB;
            S_MEM:    w_state_next = MEM_BUSYWAIT ? S_MEM : S_WB;
            S_WB:     w_state_next = S_FETCH;
            default:  w_state_next = S_FETCH;
        endcase
    end

    // Opcode decode; the full opcode field is compared, so any high bit set is illegal
    always_comb begin
        w_dec_aluop   = 3'b000;
        w_dec_comp    = 1'b0;
        w_dec_imm     = 1'b0;
        w_dec_we      = 1'b0;
        w_dec_rd      = 1'b0;
        w_dec_wr      = 1'b0;
        w_dec_m2r     = 1'b0;
        w_dec_j       = 1'b0;
        w_dec_beq     = 1'b0;
        w_dec_illegal = 1'b0;
        case (r_opcode)
            OPCODE_W'(0):  begin w_dec_imm = 1'b1; w_dec_we = 1'b1; end
            OPCODE_W'(1):  begin w_dec_we = 1'b1; end
            OPCODE_W'(2):  begin w_dec_aluop = 3'b001; w_dec_we = 1'b1; end
            OPCODE_W'(3):  begin w_dec_aluop = 3'b001; w_dec_comp = 1'b1; w_dec_we = 1'b1; end
            OPCODE_W'(4):  begin w_dec_aluop = 3'b010; w_dec_we = 1'b1; end
            OPCODE_W'(5):  begin w_dec_aluop = 3'b011; w_dec_we = 1'b1; end
            OPCODE_W'(6):  begin w_dec_j = 1'b1; end
            OPCODE_W'(7):  begin w_dec_aluop = 3'b001; w_dec_comp = 1'b1; w_dec_beq = 1'b1; end
            OPCODE_W'(8):  begin w_dec_rd = 1'b1; w_dec_we = 1'b1; w_dec_m2r = 1'b1; end
            OPCODE_W'(9):  begin w_dec_imm = 1'b1; w_dec_rd = 1'b1; w_dec_we = 1'b1; w_dec_m2r = 1'b1; end
            OPCODE_W'(10): begin w_dec_wr = 1'b1; end
            OPCODE_W'(11): begin w_dec_imm = 1'b1; w_dec_wr = 1'b1; end
`ifdef CTRL_SHIFT_OPS_EN
            OPCODE_W'(12): begin w_dec_aluop = 3'b100; w_dec_imm = 1'b1; w_dec_we = 1'b1; end
            OPCODE_W'(13): begin w_dec_aluop = 3'b101; w_dec_imm = 1'b1; w_dec_we = 1'b1; end
            OPCODE_W'(14): begin w_dec_aluop = 3'b110; w_dec_imm = 1'b1; w_dec_we = 1'b1; end
            OPCODE_W'(15): begin w_dec_aluop = 3'b111; w_dec_imm = 1'b1; w_dec_we = 1'b1; end
`endif
            default:       begin w_dec_illegal = 1'b1; end
        endcase
    end

    // Opcode latch, control registers (loaded leaving DECODE, cleared on return to FETCH) and branch flag
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_opcode  <= '0;
            r_aluop   <= 3'b000;
            r_comp    <= 1'b0;
            r_imm     <= 1'b0;
            r_we      <= 1'b0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_m2r     <= 1'b0;
            r_j       <= 1'b0;
            r_beq     <= 1'b0;
            r_illegal <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            if (r_state == S_FETCH && INSTR_VALID) begin
                r_opcode <= INSTRUCTION[INSTR_W-1 -: OPCODE_W];
            end
            if (r_state == S_DECODE) begin
                r_aluop   <= w_dec_aluop;
                r_comp    <= w_dec_comp;
                r_imm     <= w_dec_imm;
                r_we      <= w_dec_we;
                r_rd      <= w_dec_rd;
                r_wr      <= w_dec_wr;
                r_m2r     <= w_dec_m2r;
                r_j       <= w_dec_j;
                r_beq     <= w_dec_beq;
                r_illegal <= w_dec_illegal;
            end else if (w_state_next == S_FETCH) begin
                r_aluop   <= 3'b000;
                r_comp    <= 1'b0;
                r_imm     <= 1'b0;
                r_we      <= 1'b0;
                r_rd      <= 1'b0;
                r_wr      <= 1'b0;
                r_m2r     <= 1'b0;
                r_j       <= 1'b0;
                r_beq     <= 1'b0;
                r_illegal <= 1'b0;
            end
            if (r_state == S_EXEC) begin
                r_zero <= ZERO;
            end
        end
    end

    // Outputs decoded from registered state only, so reset clears them without a clock
    always_comb begin
        WRITEENABLE     = 1'b0;
        MEM_READ        = 1'b0;
        MEM_WRITE       = 1'b0;
        MEM_TO_REG      = 1'b0;
        PC_SEL          = 2'b00;
        PC_UPDATE       = 1'b0;
        ILLEGAL_OP      = 1'b0;
        ALUOP           = ALUOP_W'(r_aluop);
        COMPLEMENT_FLAG = r_comp;
        IMMEDIATE_FLAG  = r_imm;
        STATE           = r_state;
        case (r_state)
            S_EXEC: ILLEGAL_OP = r_illegal;
            S_MEM: begin
                MEM_READ  = r_rd;
                MEM_WRITE = r_wr;
            end
            S_WB: begin
                PC_UPDATE   = 1'b1;
                WRITEENABLE = r_we;
                MEM_TO_REG  = r_m2r;
                PC_SEL      = r_j ? 2'b01 : ((r_beq && r_zero) ? 2'b10 : 2'b00);
            end
            default: ;
        endcase
    end

endmodule
